// File: rtl/slot_payout_engine_pkg.sv
// Shared types, default parameters and the multiplier rule table for the slot payout engine.
package slot_pkg;

  localparam int DEF_N_REELS      = 3;
  localparam int DEF_SYM_W        = 3;
  localparam int DEF_BET_W        = 4;
  localparam int DEF_MULT_W       = 3;
  localparam int DEF_CREDIT_W     = 12;
  localparam int DEF_JACKPOT_SYM  = 7;
  localparam int DEF_ALL_MULT     = 4;
  localparam int DEF_JACKPOT_MULT = 7;
  localparam int DEF_INIT_CREDITS = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    PAY  = 2'd2
  } state_t;

  // Largest matching group -> multiplier; the trailing arguments let an
  // instance with overridden parameters reuse the same rule.
  function automatic int mult_of(
    input int best_cnt,
    input int best_sym,
    input int n_reels      = DEF_N_REELS,
    input int jackpot_sym  = DEF_JACKPOT_SYM,
    input int all_mult     = DEF_ALL_MULT,
    input int jackpot_mult = DEF_JACKPOT_MULT
  );
    if (best_cnt == n_reels && best_sym == jackpot_sym) return jackpot_mult;
    if (best_cnt == n_reels)                            return all_mult;
    if (best_cnt >= 2)                                  return best_cnt - 1;
    return 0;
  endfunction

endpackage

// File: rtl/slot_payout_engine_if.sv
// Spin/credit bus between the reel controller, the payout engine and the credit display.
interface slot_payout_engine_if
  import slot_pkg::*;
#(
  parameter int N_REELS  = DEF_N_REELS,
  parameter int SYM_W    = DEF_SYM_W,
  parameter int BET_W    = DEF_BET_W,
  parameter int MULT_W   = DEF_MULT_W,
  parameter int CREDIT_W = DEF_CREDIT_W
) ();

  // Handshake: start is a level request sampled only while the engine is idle
  // (busy=0); each sampled start yields exactly one of reject (refused, same
  // cycle after the edge) or, N_REELS+1 edges later, done. start while busy is
  // dropped silently. cards_in/bet need only be valid on the accepting edge.
  logic                        start;
  logic [N_REELS*SYM_W-1:0]    cards_in;
  logic [BET_W-1:0]            bet;
  logic                        coin;
  logic                        busy;
  logic [MULT_W-1:0]           multiplier;
  logic [CREDIT_W-1:0]         payout;
  logic [CREDIT_W-1:0]         credits;
  logic                        done;
  logic                        reject;
  state_t                      state_dbg;

  modport master (
    output start, cards_in, bet, coin,
    input  busy, multiplier, payout, credits, done, reject, state_dbg
  );

  modport slave (
    input  start, cards_in, bet, coin,
    output busy, multiplier, payout, credits, done, reject, state_dbg
  );

endinterface

// File: rtl/slot_payout_engine_reel_match_counter.sv
// Counts how many reels show the same symbol as reel idx (idx itself included).
module reel_match_counter #(
  parameter int N_REELS = 3,
  parameter int SYM_W   = 3,
  parameter int IDX_W   = $clog2(N_REELS),
  parameter int CNT_W   = $clog2(N_REELS + 1)
) (
  input  logic [N_REELS*SYM_W-1:0] cards,
  input  logic [IDX_W-1:0]         idx,
  output logic [CNT_W-1:0]         cnt
);

  logic [SYM_W-1:0] ref_sym;

  assign ref_sym = cards[int'(idx)*SYM_W +: SYM_W];

  always_comb begin
    cnt = '0;
    for (int j = 0; j < N_REELS; j++) begin
      if (cards[j*SYM_W +: SYM_W] == ref_sym) cnt = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/slot_payout_engine.sv
// Sequential slot evaluator: scans one reel per cycle for the largest match group,
// pays bet*multiplier into a saturating credit balance, and accepts coin pulses.
module slot_payout_engine
  import slot_pkg::*;
#(
  parameter int N_REELS      = DEF_N_REELS,
  parameter int SYM_W        = DEF_SYM_W,
  parameter int BET_W        = DEF_BET_W,
  parameter int MULT_W       = DEF_MULT_W,
  parameter int CREDIT_W     = DEF_CREDIT_W,
  parameter int JACKPOT_SYM  = DEF_JACKPOT_SYM,
  parameter int ALL_MULT     = DEF_ALL_MULT,
  parameter int JACKPOT_MULT = DEF_JACKPOT_MULT,
  parameter int INIT_CREDITS = DEF_INIT_CREDITS
) (
  input logic clk,
  input logic rst,
  slot_payout_engine_if.slave bus
);

  localparam int IDX_W  = $clog2(N_REELS);
  localparam int CNT_W  = $clog2(N_REELS + 1);
  localparam int PROD_W = BET_W + MULT_W;
  // Wide enough that credits+payout+coin cannot wrap before saturation.
  localparam int EXT_W  = ((PROD_W > CREDIT_W) ? PROD_W : CREDIT_W) + 2;
  localparam logic [EXT_W-1:0] CREDIT_MAX = EXT_W'({CREDIT_W{1'b1}});

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         best_cnt_q, best_cnt_d;
  logic [SYM_W-1:0]         best_sym_q, best_sym_d;
  logic [N_REELS*SYM_W-1:0] cards_q, cards_d;
  logic [BET_W-1:0]         bet_q, bet_d;
  logic [CREDIT_W-1:0]      credits_q, credits_d;
  logic [MULT_W-1:0]        mult_q, mult_d;
  logic [CREDIT_W-1:0]      payout_q, payout_d;
  logic                     done_q, done_d;
  logic                     reject_q, reject_d;

  logic [CNT_W-1:0]         cnt;
  logic [SYM_W-1:0]         cur_sym;
  logic [MULT_W-1:0]        mult_now;
  logic [PROD_W-1:0]        prod;
  logic [EXT_W-1:0]         prod_sat;
  logic [EXT_W-1:0]         credits_ext, bet_ext, coin_ext;

  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [EXT_W-1:0] v);
    return (v > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0] : v[CREDIT_W-1:0];
  endfunction

  reel_match_counter #(
    .N_REELS (N_REELS),
    .SYM_W   (SYM_W),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_match (
    .cards (cards_q),
    .idx   (idx_q),
    .cnt   (cnt)
  );

  assign cur_sym     = cards_q[int'(idx_q)*SYM_W +: SYM_W];
  assign mult_now    = MULT_W'(mult_of(int'(best_cnt_q), int'(best_sym_q),
                                       N_REELS, JACKPOT_SYM, ALL_MULT, JACKPOT_MULT));
  assign prod        = {{MULT_W{1'b0}}, bet_q} * {{BET_W{1'b0}}, mult_now};
  assign prod_sat    = (EXT_W'(prod) > CREDIT_MAX) ? CREDIT_MAX : EXT_W'(prod);
  assign credits_ext = EXT_W'(credits_q);
  assign bet_ext     = EXT_W'(bus.bet);
  assign coin_ext    = EXT_W'(bus.coin);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_cnt_d = best_cnt_q;
    best_sym_d = best_sym_q;
    cards_d    = cards_q;
    bet_d      = bet_q;
    mult_d     = mult_q;
    payout_d   = payout_q;
    done_d     = 1'b0;
    reject_d   = 1'b0;
    credits_d  = sat_credit(credits_ext + coin_ext);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.bet != '0 && credits_ext >= bet_ext) begin
            cards_d    = bus.cards_in;
            bet_d      = bus.bet;
            idx_d      = '0;
            best_cnt_d = '0;
            best_sym_d = '0;
            // bet >= 1 here, so the coin can never push this past the maximum.
            credits_d  = CREDIT_W'(credits_ext - bet_ext + coin_ext);
            state_d    = SCAN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest reel index on ties.
        if (cnt > best_cnt_q) begin
          best_cnt_d = cnt;
          best_sym_d = cur_sym;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_REELS - 1)) state_d = PAY;
      end
      PAY: begin
        mult_d    = mult_now;
        payout_d  = prod_sat[CREDIT_W-1:0];
        credits_d = sat_credit(credits_ext + prod_sat + coin_ext);
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      best_cnt_q <= '0;
      best_sym_q <= '0;
      cards_q    <= '0;
      bet_q      <= '0;
      credits_q  <= CREDIT_W'(INIT_CREDITS);
      mult_q     <= '0;
      payout_q   <= '0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_cnt_q <= best_cnt_d;
      best_sym_q <= best_sym_d;
      cards_q    <= cards_d;
      bet_q      <= bet_d;
      credits_q  <= credits_d;
      mult_q     <= mult_d;
      payout_q   <= payout_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.multiplier = mult_q;
  assign bus.payout     = payout_q;
  assign bus.credits    = credits_q;
  assign bus.done       = done_q;
  assign bus.reject     = reject_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_slot_payout_engine.sv
// Directed bench for slot_payout_engine: spins scored through an expected queue.
module tb_slot_payout_engine;
  import slot_pkg::*;

  localparam int W = 3 + 12 + 12;  // {multiplier, payout, credits}
  localparam int CMAX = 4095;

  logic clk;
  logic rst;
  slot_payout_engine_if bus ();

  slot_payout_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_credits = 0;
  logic [W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_mult(input int c0, input int c1, input int c2);
    if (c0 == c1 && c1 == c2) return (c0 == 7) ? 7 : 4;
    if (c0 == c1 || c1 == c2 || c0 == c2) return 1;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    bus.start = 1'b0; bus.coin = 1'b0; bus.bet = '0; bus.cards_in = '0;
    rst = 1'b1;
    tick();
    check("rst_credits", 32'(bus.credits), 0);
    check("rst_mult",    32'(bus.multiplier), 0);
    check("rst_payout",  32'(bus.payout), 0);
    check("rst_done",    32'(bus.done), 0);
    check("rst_reject",  32'(bus.reject), 0);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_state",   32'(bus.state_dbg), 32'(IDLE));
    rst = 1'b0;
    m_credits = 0;
  endtask

  task automatic insert_coins(input int n);
    bus.coin = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_credits < CMAX) m_credits++;
    end
    bus.coin = 1'b0;
  endtask

  task automatic try_reject(input int b);
    bus.start = 1'b1; bus.bet = 4'(b); bus.cards_in = 9'h0;
    tick();
    bus.start = 1'b0;
    check("rej_pulse",   32'(bus.reject), 1);
    check("rej_busy",    32'(bus.busy), 0);
    check("rej_credits", 32'(bus.credits), 32'(m_credits));
    tick();
    check("rej_clear",   32'(bus.reject), 0);
    check("rej_nodone",  32'(bus.done), 0);
  endtask

  task automatic spin(input int c0, input int c1, input int c2, input int b,
                      input bit coin_acc, input bit coin_pay);
    int m, pay, scan_credits, waited;
    logic [W-1:0] e;
    m   = model_mult(c0, c1, c2);
    pay = b * m;
    if (pay > CMAX) pay = CMAX;
    m_credits    = m_credits - b + int'(coin_acc);
    scan_credits = m_credits;
    m_credits    = m_credits + pay + int'(coin_pay);
    if (m_credits > CMAX) m_credits = CMAX;
    exp_q.push_back({3'(m), 12'(pay), 12'(m_credits)});

    bus.start = 1'b1; bus.cards_in = {3'(c2), 3'(c1), 3'(c0)}; bus.bet = 4'(b);
    bus.coin  = coin_acc;
    tick();                                          // edge 0: accept
    bus.start = 1'b0; bus.coin = 1'b0;
    bus.bet = '0; bus.cards_in = 9'(~{3'(c2), 3'(c1), 3'(c0)});  // must be latched
    check("scan_busy",    32'(bus.busy), 1);
    check("scan_credits", 32'(bus.credits), 32'(scan_credits));
    tick(); tick(); tick();                          // edges 1..3
    check("done_early", 32'(bus.done), 0);
    bus.coin = coin_pay;
    tick();                                          // edge 4: PAY -> IDLE
    bus.coin = 1'b0;
    waited = 0;
    while (bus.done !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check("done_latency", 32'(waited), 0);
    e = exp_q.pop_front();
    if (bus.done === 1'b1) begin
      check("mult",    32'(bus.multiplier), 32'(e[26:24]));
      check("payout",  32'(bus.payout),     32'(e[23:12]));
      check("credits", 32'(bus.credits),    32'(e[11:0]));
    end
    tick();
    check("done_pulse", 32'(bus.done), 0);
    check("idle_busy",  32'(bus.busy), 0);
    check("hold_mult",  32'(bus.multiplier), 32'(e[26:24]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.coin = 1'b0; bus.bet = '0; bus.cards_in = '0;
    #2;
    apply_reset();

    // 1: coins
    insert_coins(5);
    check("t1_credits", 32'(bus.credits), 5);
    check("t1_done",    32'(bus.done), 0);
    check("t1_reject",  32'(bus.reject), 0);

    // 2: pair
    spin(3, 3, 5, 2, 1'b0, 1'b0);

    // 3: jackpot and plain all-match from 10
    insert_coins(5);
    spin(7, 7, 7, 3, 1'b0, 1'b0);
    spin(1, 2, 4, 15, 1'b0, 1'b0);
    spin(1, 2, 4, 3, 1'b0, 1'b0);
    check("t3_ten", 32'(bus.credits), 10);
    spin(2, 2, 2, 3, 1'b0, 1'b0);

    // 4: refusals then a losing spin
    spin(1, 2, 4, 14, 1'b0, 1'b0);
    try_reject(6);
    try_reject(0);
    spin(1, 2, 4, 1, 1'b0, 1'b0);

    // start while busy is ignored
    bus.start = 1'b1; bus.bet = 4'd1; bus.cards_in = '0;
    tick();
    bus.start = 1'b0;
    m_credits = m_credits - 1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_noreject", 32'(bus.reject), 0);
    tick(); tick(); tick();
    m_credits = m_credits + 4;                      // cards (0,0,0) -> x4
    check("busy_spin_credits", 32'(bus.credits), 32'(m_credits));

    // 5: saturation, then coin on the accept cycle
    apply_reset();
    insert_coins(4094);
    check("t5_pre", 32'(bus.credits), 4094);
    spin(7, 7, 7, 4, 1'b0, 1'b1);
    apply_reset();
    insert_coins(5);
    spin(6, 6, 1, 2, 1'b1, 1'b0);

    // 6: reset mid-scan
    insert_coins(3);
    check("t6_nine", 32'(bus.credits), 9);
    bus.start = 1'b1; bus.bet = 4'd1; bus.cards_in = {3'd5, 3'd5, 3'd5};
    tick();
    bus.start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6_credits", 32'(bus.credits), 0);
    check("t6_busy",    32'(bus.busy), 0);
    check("t6_done",    32'(bus.done), 0);
    check("t6_mult",    32'(bus.multiplier), 0);
    @(negedge clk) rst = 1'b0;
    tick();
    m_credits = 0;
    insert_coins(3);
    spin(5, 5, 5, 1, 1'b0, 1'b0);
    check("t6_final", 32'(bus.credits), 6);

    // random spins
    for (int k = 0; k < 6; k++) begin
      int b, hi;
      if (m_credits < 1) insert_coins(3);
      hi = (m_credits < 15) ? m_credits : 15;
      b  = $urandom_range(1, hi);
      spin($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // ---------------- report ----------------
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_payout_engine.md
Name: slot_payout_engine

Overview:
Sequential, parametrised successor to the combinational card-to-multiplier evaluator. It accepts one spin of N_REELS symbols plus a bet, scans the reels one reel per cycle for the largest group of matching symbols, maps that result to a multiplier, and credits bet*multiplier to an internal saturating credit balance. It sits between the reel/spin controller and the credit display, and also accepts coin-insert pulses.

Parameters:
N_REELS, 3, number of reels (>=2)
SYM_W, 3, symbol width per reel
BET_W, 4, bet width
MULT_W, 3, multiplier width; ALL_MULT and JACKPOT_MULT must fit
CREDIT_W, 12, credit balance and payout width
JACKPOT_SYM, 7, symbol that promotes an all-match to jackpot
ALL_MULT, 4, multiplier for an all-match on a non-jackpot symbol
JACKPOT_MULT, 7, multiplier for an all-match on JACKPOT_SYM
INIT_CREDITS, 0, credit value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  spin request; sampled only in IDLE
cards_in  in  N_REELS*SYM_W  reel symbols; reel i = bits [i*SYM_W +: SYM_W]
bet  in  BET_W  wager for this spin
coin  in  1  +1 credit per cycle while high
busy  out  1  high in SCAN and PAY
multiplier  out  MULT_W  multiplier of the last completed spin
payout  out  CREDIT_W  bet*multiplier of the last completed spin, saturated
credits  out  CREDIT_W  current balance
done  out  1  one-cycle pulse when a spin completes
reject  out  1  one-cycle pulse when start is refused

Behaviour:
- Reset (async, any state): FSM goes to IDLE. credits=INIT_CREDITS. multiplier, payout, done, reject and busy are 0. A spin in flight is abandoned and its bet is not refunded.
- FSM states: IDLE, SCAN, PAY.
- IDLE, start=1 with bet!=0 and credits>=bet: latch cards_in and bet, deduct bet from credits, clear idx/best_cnt/best_sym, go to SCAN.
- IDLE, start=1 with bet==0 or credits<bet: pulse reject for 1 cycle, stay in IDLE, credits unchanged except for coin.
- start outside IDLE is ignored, with no reject.
- SCAN, one cycle per reel idx=0..N_REELS-1:
  - cnt = number of reels j with card[j]==card[idx]; cnt includes idx itself, so 1..N_REELS.
  - If cnt>best_cnt: best_cnt=cnt, best_sym=card[idx]. Ties keep the lower idx.
  - After idx==N_REELS-1, go to PAY.
- Multiplier rule, applied in PAY:
  - best_cnt==N_REELS and best_sym==JACKPOT_SYM -> JACKPOT_MULT
  - best_cnt==N_REELS otherwise -> ALL_MULT
  - 2<=best_cnt<N_REELS -> best_cnt-1
  - else -> 0
- PAY, single cycle:
  - Register multiplier and payout = min(bet*mult, 2^CREDIT_W-1). The product is computed at BET_W+MULT_W bits before saturation.
  - credits += payout, saturating at 2^CREDIT_W-1.
  - Pulse done, return to IDLE.
- Latency: start accepted at edge 0; done, multiplier, payout and the credited balance are visible after edge N_REELS+1. With the defaults that is edge 4. The next start is accepted on the cycle after done.
- multiplier and payout hold until the next done.
- coin is honoured in every state and folded into the same credits update:
  - With bet deduct: credits-bet+1. No underflow is possible.
  - With payout: credits+payout+1, saturated.
- credits never wraps.

Decomposition:
- Package slot_pkg holds the FSM state enum (IDLE/SCAN/PAY) and a pure function mult_of(best_cnt, best_sym) implementing the rule table, parametrised via the package's parameter defaults.
- One sub-module, reel_match_counter: combinational; inputs are the packed cards and idx; output is cnt, clog2(N_REELS+1) bits wide. Instantiated once in the SCAN datapath.

Test Plan:
1. Reset, then coin high for 5 cycles -> credits=5, multiplier=0, payout=0, no done, no reject.
2. credits=5, bet=2, cards (3,3,5) -> done at edge 4 after start, multiplier=1, payout=2, credits=5.
3. credits=10, bet=3, cards (7,7,7) -> multiplier=7, payout=21, credits=28. Repeat with cards (2,2,2) from 10 -> multiplier=4, payout=12, credits=19.
4. credits=5, bet=6 -> reject 1 cycle, credits=5, busy=0, no done. Then bet=0 -> reject again. Then cards (1,2,4), bet=1 -> multiplier=0, payout=0, credits=4.
5. credits=4094, bet=4, cards (7,7,7), coin=1 on the PAY cycle -> payout=28, credits saturates at 4095. Separately, coin=1 on the accept cycle with credits=5 and bet=2 -> credits=4 during SCAN.
6. rst asserted mid-SCAN (idx=1) with INIT_CREDITS=0 and credits=9 -> immediately credits=0, busy=0, no done. A new start with coins 3, bet=1, cards (5,5,5) -> multiplier=4, credits=6.
